// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Commits arrive in order from the ROB; the decoder reads operands combinationally and locks destinations.
module reg_status_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_WIDTH   = 5,
  parameter int REG_NUMBER  = 32,
  parameter int ENTRY_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read1,
  input  logic [REG_WIDTH-1:0]   read_name1,
  output logic [DATA_WIDTH-1:0]  read_value1,
  output logic                   read_busy1,
  output logic [ENTRY_WIDTH-1:0] read_entry1,
  input  logic                   read2,
  input  logic [REG_WIDTH-1:0]   read_name2,
  output logic [DATA_WIDTH-1:0]  read_value2,
  output logic                   read_busy2,
  output logic [ENTRY_WIDTH-1:0] read_entry2,
  input  logic                   lock,
  input  logic [REG_WIDTH-1:0]   lock_name,
  input  logic [ENTRY_WIDTH-1:0] lock_entry,
  input  logic                   reg_modify,
  input  logic [REG_WIDTH-1:0]   reg_name,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  input  logic [ENTRY_WIDTH-1:0] reg_entry,
  input  logic                   flush
);

  // Interface contract: no valid/ready handshake exists here. read, lock and
  // reg_modify are single-cycle strobes that are always accepted; reads are
  // combinational and never observe a lock presented in the same cycle.

  logic [DATA_WIDTH-1:0]  data_q [REG_NUMBER];
  logic [ENTRY_WIDTH-1:0] tag_q  [REG_NUMBER];
  logic [REG_NUMBER-1:0]  busy_q;

  logic commit_en;
  logic commit_clear;
  logic lock_en;
  logic read_ok1;
  logic read_ok2;

  // Register 0 is hardwired to zero; names beyond REG_NUMBER are ignored.
  assign commit_en = reg_modify && (reg_name != '0) && (32'(reg_name) < 32'(REG_NUMBER));
  assign lock_en   = lock && !flush && (lock_name != '0) && (32'(lock_name) < 32'(REG_NUMBER));
  assign read_ok1  = read1 && (read_name1 != '0) && (32'(read_name1) < 32'(REG_NUMBER));
  assign read_ok2  = read2 && (read_name2 != '0) && (32'(read_name2) < 32'(REG_NUMBER));

  // A commit only releases the register if it is still the newest producer.
  assign commit_clear = commit_en && busy_q[reg_name] && (tag_q[reg_name] == reg_entry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUMBER; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < REG_NUMBER; i++) begin
        if (commit_en && (reg_name == REG_WIDTH'(i))) begin
          data_q[i] <= reg_data;
        end
        if (flush) begin
          busy_q[i] <= 1'b0;
        end else if (lock_en && (lock_name == REG_WIDTH'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= lock_entry;
        end else if (commit_clear && (reg_name == REG_WIDTH'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Operand port 1, with same-cycle commit bypass.
  always_comb begin
    read_value1 = '0;
    read_busy1  = 1'b0;
    read_entry1 = '0;
    if (read_ok1) begin
      read_value1 = data_q[read_name1];
      read_busy1  = busy_q[read_name1];
      read_entry1 = tag_q[read_name1];
      if (reg_modify && (reg_name == read_name1) && busy_q[read_name1] &&
          (tag_q[read_name1] == reg_entry)) begin
        read_value1 = reg_data;
        read_busy1  = 1'b0;
      end
    end
  end

  // Operand port 2, identical to port 1.
  always_comb begin
    read_value2 = '0;
    read_busy2  = 1'b0;
    read_entry2 = '0;
    if (read_ok2) begin
      read_value2 = data_q[read_name2];
      read_busy2  = busy_q[read_name2];
      read_entry2 = tag_q[read_name2];
      if (reg_modify && (reg_name == read_name2) && busy_q[read_name2] &&
          (tag_q[read_name2] == reg_entry)) begin
        read_value2 = reg_data;
        read_busy2  = 1'b0;
      end
    end
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status. Sits directly downstream of the reorder buffer.
- Accepts in-order commits from the reorder buffer: data, destination register and the committing ROB entry.
- Serves the decoder: two operand read ports, each returning either the committed value or the ROB entry that will produce it.
- The decoder tags a destination register with its newly allocated ROB entry when it issues an instruction.

Parameters:
DATA_WIDTH, 32, register data width (matches Data_Width)
REG_WIDTH, 5, register name width (matches Reg_Width)
REG_NUMBER, 32, number of architectural registers
ENTRY_WIDTH, 3, ROB entry tag width (matches ROB_Entry_Width)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
read1  in  1  operand port 1 read request
read_name1  in  REG_WIDTH  operand port 1 register name
read_value1  out  DATA_WIDTH  committed value (valid when read_busy1=0)
read_busy1  out  1  register awaits result from ROB
read_entry1  out  ENTRY_WIDTH  producing ROB entry (valid when read_busy1=1)
read2, read_name2, read_value2, read_busy2, read_entry2  same as port 1
lock  in  1  decoder issues instruction writing lock_name
lock_name  in  REG_WIDTH  destination register
lock_entry  in  ENTRY_WIDTH  ROB entry allocated (ROB out_lock)
reg_modify  in  1  ROB commit strobe
reg_name  in  REG_WIDTH  commit destination
reg_data  in  DATA_WIDTH  commit value
reg_entry  in  ENTRY_WIDTH  committing ROB entry
flush  in  1  discard all speculative locks (misprediction recovery)

Behaviour:
- State per register: data[DATA_WIDTH], busy, tag[ENTRY_WIDTH].
- Reset (rst=0, asynchronous): all data=0, busy=0, tag=0. Reads are combinational, so outputs follow the rules below immediately.
- Register 0 is hardwired:
  - reads always return value 0, busy 0, entry 0;
  - locks and commits to register 0 are ignored.
- Read port (combinational, zero latency):
  - read=0: value=0, busy=0, entry=0.
  - read=1: start from stored data/busy/tag.
  - Commit bypass: if reg_modify, reg_name==read_name, stored busy=1 and tag==reg_entry, return value=reg_data, busy=0.
  - Otherwise return the stored state.
  - Reads never see a same-cycle lock. The decoder reads sources before locking the destination, e.g. add r1,r1,r2 reads the old r1 status.
- Commit (sequential):
  - reg_modify=1 and reg_name!=0: data[reg_name] <= reg_data unconditionally, since commits are in order.
  - busy[reg_name] <= 0 only if busy=1 and tag==reg_entry.
  - If the tag differs, a younger instruction still owns the register; busy and tag are unchanged.
- Lock (sequential):
  - lock=1, lock_name!=0, flush=0: busy[lock_name] <= 1, tag[lock_name] <= lock_entry.
  - Overwrites any earlier tag (newest producer wins).
- Simultaneous commit and lock to the same register: data is written, lock wins (busy=1, tag=lock_entry), regardless of tag match.
- Flush: all busy <= 0 next edge; a same-cycle lock is ignored; a same-cycle commit data write still happens. Tags are left unchanged (don't care while busy=0).
- Both read ports are independent and may address the same register.
- No backpressure: every request is accepted every cycle.
- Mid-operation reset clears all state immediately, without waiting for a clock edge.

Test Plan:
1. Reset then read1 r5 -> value 0, busy 0, entry 0. Read r0 after reg_modify r0=0xFFFF -> value 0.
2. Lock r3 tag 2. Next cycle read1 r3 -> busy 1, entry 2. Commit r3=0x1234 entry 2 -> same-cycle read gives value 0x1234, busy 0. Following cycle, stored busy is 0.
3. Lock r4 tag 1, then lock r4 tag 5. Commit r4=0xAA entry 1 -> data 0xAA, busy stays 1, entry 5. Commit r4=0xBB entry 5 -> busy 0, value 0xBB.
4. Same cycle: commit r6 entry 3 (matching) and lock r6 tag 7 -> next cycle busy 1, entry 7, stored data = commit value. Same-cycle read of r6 shows the bypassed commit value, busy 0.
5. Lock r1, r2, r7 with tags 0, 1, 2. Assert flush together with lock r8 tag 3 and commit r9=0x55 -> r1, r2, r7, r8 busy 0; r9 value 0x55.
6. Both ports read r10 while locked tag 4; assert rst=0 mid-cycle -> outputs immediately value 0, busy 0, entry 0.
